// File: rtl/redmule_mx_pkg.sv
// Shared MX definitions: block-exponent width and the default lane type.
// Imported by the MX staging/chunking FIFO and its chunk selector.
package redmule_mx_pkg;

   localparam int MX_EXP_W = 8;
   localparam int MX_BITW  = 16;

   typedef logic [MX_BITW-1:0] mx_lane_t;

endpackage

// File: rtl/redmule_mx_chunk_sel.sv
// Pure combinational mux: picks lanes [beat*CHUNK_LANES +: CHUNK_LANES] of a
// full MX vector, lane 0 of the slice in the lowest position.
module redmule_mx_chunk_sel
   import redmule_mx_pkg::*;
#(
   parameter int NUM_LANES   = 12,
   parameter int CHUNK_LANES = 4,
   parameter int BITW        = MX_BITW,
   parameter int BW          = 2
) (
   input  logic [NUM_LANES-1:0][BITW-1:0]   i_lanes,
   input  logic [BW-1:0]                    i_beat,
   output logic [CHUNK_LANES-1:0][BITW-1:0] o_chunk
);

   localparam int BEATS = NUM_LANES / CHUNK_LANES;

   always_comb begin
      o_chunk = i_lanes[CHUNK_LANES-1:0];
      for (int k = 0; k < BEATS; k++) begin
         if (i_beat == BW'(k)) begin
            o_chunk = i_lanes[k*CHUNK_LANES +: CHUNK_LANES];
         end
      end
   end

endmodule

// File: rtl/redmule_mx_chunk_fifo.sv
// MX staging FIFO: stores full-width vectors plus shared exponent and drains
// each entry as BEATS narrower beats; any depth >= 2, with count and almost-full.
module redmule_mx_chunk_fifo
   import redmule_mx_pkg::*;
#(
   parameter int DATA_WIDTH  = 192,
   parameter int BITW        = 16,
   parameter int CHUNK_LANES = 4,
   parameter int FIFO_DEPTH  = 6,
   parameter int EXP_WIDTH   = MX_EXP_W,
   parameter int AF_THRESH   = FIFO_DEPTH - 1
) (
   input  logic                                       clk_i,
   input  logic                                       rst_ni,
   input  logic                                       clear_i,
   input  logic                                       push_i,
   output logic                                       grant_o,
   input  logic [DATA_WIDTH/BITW-1:0][BITW-1:0]       data_i,
   input  logic [EXP_WIDTH-1:0]                       exp_i,
   input  logic                                       pop_i,
   output logic                                       valid_o,
   output logic [CHUNK_LANES-1:0][BITW-1:0]           data_o,
   output logic [EXP_WIDTH-1:0]                       exp_o,
   output logic                                       first_o,
   output logic                                       last_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]            count_o,
   output logic                                       almost_full_o
);

   localparam int NUM_LANES = DATA_WIDTH / BITW;
   localparam int BEATS     = NUM_LANES / CHUNK_LANES;
   localparam int CW        = $clog2(FIFO_DEPTH + 1);
   localparam int PW        = $clog2(FIFO_DEPTH);
   localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1;

   if (NUM_LANES % CHUNK_LANES != 0) begin : g_bad_chunk
      $error("NUM_LANES must be a multiple of CHUNK_LANES");
   end
   if (FIFO_DEPTH < 2) begin : g_bad_depth
      $error("FIFO_DEPTH must be at least 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
      $error("AF_THRESH must lie in 1..FIFO_DEPTH");
   end

   // Handshake: a push transfers when push_i && grant_o, a beat transfers when
   // pop_i && valid_o; grant_o/valid_o depend on registered state only, and
   // requests made while the matching flag is low are ignored.

   logic [NUM_LANES-1:0][BITW-1:0] r_mem_data [FIFO_DEPTH];
   logic [EXP_WIDTH-1:0]           r_mem_exp  [FIFO_DEPTH];

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [BW-1:0] r_beat;

   logic          w_grant;
   logic          w_valid;
   logic          w_push_ok;
   logic          w_pop_ok;
   logic          w_last_beat;
   logic          w_retire;
   logic [PW-1:0] w_wr_ptr_nxt;
   logic [PW-1:0] w_rd_ptr_nxt;
   logic [NUM_LANES-1:0][BITW-1:0] w_head_data;

   assign w_grant     = (r_count != CW'(FIFO_DEPTH));
   assign w_valid     = (r_count != '0);
   assign w_push_ok   = push_i && w_grant;
   assign w_pop_ok    = pop_i && w_valid;
   assign w_last_beat = (r_beat == BW'(BEATS - 1));
   assign w_retire    = w_pop_ok && w_last_beat;

   // Depth need not be a power of two, so pointers wrap explicitly.
   assign w_wr_ptr_nxt = (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
   assign w_rd_ptr_nxt = (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_beat   <= '0;
      end else if (clear_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_beat   <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= w_wr_ptr_nxt;
         end
         if (w_pop_ok) begin
            if (w_last_beat) begin
               r_beat   <= '0;
               r_rd_ptr <= w_rd_ptr_nxt;
            end else begin
               r_beat <= r_beat + BW'(1);
            end
         end
         case ({w_push_ok, w_retire})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push_ok && !clear_i) begin
         r_mem_data[r_wr_ptr] <= data_i;
         r_mem_exp[r_wr_ptr]  <= exp_i;
      end
   end

   assign w_head_data = r_mem_data[r_rd_ptr];

   redmule_mx_chunk_sel #(
      .NUM_LANES   (NUM_LANES),
      .CHUNK_LANES (CHUNK_LANES),
      .BITW        (BITW),
      .BW          (BW)
   ) u_chunk_sel (
      .i_lanes (w_head_data),
      .i_beat  (r_beat),
      .o_chunk (data_o)
   );

   assign grant_o       = w_grant;
   assign valid_o       = w_valid;
   assign exp_o         = r_mem_exp[r_rd_ptr];
   assign first_o       = w_valid && (r_beat == '0);
   assign last_o        = w_valid && w_last_beat;
   assign count_o       = r_count;
   assign almost_full_o = (r_count >= CW'(AF_THRESH));

   a_push_granted : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && !w_grant))
      else $error("push request while FIFO is full");

   a_pop_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(pop_i && !w_valid))
      else $error("pop request while FIFO is empty");

endmodule
